// File: rtl/seq_round_ctrl_if.sv
// Handshake/bus bundle for the memory-game round controller.
// The master side drives the player/timer inputs; the slave side is the controller.
interface seq_round_ctrl_if;
  logic       start;
  logic [3:0] randNum;
  logic       tick;
  logic       p_valid;
  logic [3:0] p_num;
  logic       timer_en;
  logic [4:0] disp_num;
  logic [4:0] seq_len;
  logic [4:0] score;
  logic       win;
  logic       lose;
  logic       busy;

  modport master (
    output start, randNum, tick, p_valid, p_num,
    input  timer_en, disp_num, seq_len, score, win, lose, busy
  );

  modport slave (
    input  start, randNum, tick, p_valid, p_num,
    output timer_en, disp_num, seq_len, score, win, lose, busy
  );
endinterface

// File: rtl/seq_round_ctrl.sv
// Memory-game round controller: grows a random digit sequence one digit per round,
// replays it on timer ticks, then checks the player's entries digit by digit.
module seq_round_ctrl #(
  parameter int unsigned MAX_LEN = 16
) (
  input logic             Clk,
  input logic             Rst,
  seq_round_ctrl_if.slave bus
);

  localparam int unsigned AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [4:0]  MAX_LEN5 = 5'(MAX_LEN);
  localparam logic [4:0]  BLANK    = 5'h1F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_APPEND,
    S_SHOW,
    S_INPUT,
    S_WIN,
    S_LOSE
  } state_e;

  state_e     state_q, state_d;
  logic [4:0] len_q, len_d;
  logic [4:0] idx_q, idx_d;
  logic [4:0] score_q, score_d;
  logic [3:0] seq_buf_q [MAX_LEN];
  logic [3:0] cur_digit;
  logic       last_digit;
  logic       wr_en;

  assign cur_digit  = seq_buf_q[idx_q[AW-1:0]];
  assign last_digit = (idx_q == len_q - 5'd1);

  // Buffer is intentionally not reset: every entry is written before it is read.
  always_ff @(posedge Clk) begin
    if (wr_en) begin
      seq_buf_q[len_q[AW-1:0]] <= bus.randNum;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      score_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    score_d = score_q;
    wr_en   = 1'b0;
    case (state_q)
      S_IDLE, S_WIN, S_LOSE: begin
        if (bus.start) begin
          len_d   = '0;
          idx_d   = '0;
          score_d = '0;
          state_d = S_APPEND;
        end
      end
      S_APPEND: begin
        if (len_q < MAX_LEN5) begin
          wr_en = 1'b1;
          len_d = len_q + 5'd1;
        end
        idx_d   = '0;
        state_d = S_SHOW;
      end
      S_SHOW: begin
        if (bus.tick) begin
          if (last_digit) begin
            idx_d   = '0;
            state_d = S_INPUT;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      S_INPUT: begin
        if (bus.p_valid) begin
          if (bus.p_num != cur_digit) begin
            state_d = S_LOSE;
          end else if (last_digit) begin
            if (score_q < MAX_LEN5) begin
              score_d = score_q + 5'd1;
            end
            state_d = (len_q == MAX_LEN5) ? S_WIN : S_APPEND;
          end else begin
            idx_d = idx_q + 5'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs depend only on registered state, never directly on inputs.
  always_comb begin
    bus.timer_en = 1'b0;
    bus.disp_num = BLANK;
    bus.seq_len  = len_q;
    bus.score    = score_q;
    bus.win      = (state_q == S_WIN);
    bus.lose     = (state_q == S_LOSE);
    bus.busy     = (state_q == S_APPEND) || (state_q == S_SHOW) || (state_q == S_INPUT);
    if (state_q == S_SHOW) begin
      bus.timer_en = 1'b1;
      bus.disp_num = {1'b0, cur_digit};
    end
  end

endmodule

// File: tb/tb_seq_round_ctrl.sv
// Randomized game-playing bench with a queue-based scoreboard for two controller
// instances (default length and MAX_LEN=2).
module tb_seq_round_ctrl;

  logic       Clk = 1'b0;
  logic       Rst = 1'b0;
  logic       start = 1'b0;
  logic       tick = 1'b0;
  logic       p_valid = 1'b0;
  logic [3:0] randNum = '0;
  logic [3:0] p_num = '0;
  logic       dsel = 1'b0;

  int checks = 0;
  int errors = 0;

  always #5 Clk = ~Clk;

  seq_round_ctrl_if bus_a ();
  seq_round_ctrl_if bus_b ();

  assign bus_a.start   = start & ~dsel;
  assign bus_b.start   = start & dsel;
  assign bus_a.tick    = tick;
  assign bus_b.tick    = tick;
  assign bus_a.p_valid = p_valid;
  assign bus_b.p_valid = p_valid;
  assign bus_a.p_num   = p_num;
  assign bus_b.p_num   = p_num;
  assign bus_a.randNum = randNum;
  assign bus_b.randNum = randNum;

  seq_round_ctrl dut_a (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_a)
  );

  seq_round_ctrl #(.MAX_LEN(2)) dut_b (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus_b)
  );

  logic       m_timer_en, m_win, m_lose, m_busy;
  logic [4:0] m_disp, m_len, m_score;
  assign m_timer_en = dsel ? bus_b.timer_en : bus_a.timer_en;
  assign m_win      = dsel ? bus_b.win      : bus_a.win;
  assign m_lose     = dsel ? bus_b.lose     : bus_a.lose;
  assign m_busy     = dsel ? bus_b.busy     : bus_a.busy;
  assign m_disp     = dsel ? bus_b.disp_num : bus_a.disp_num;
  assign m_len      = dsel ? bus_b.seq_len  : bus_a.seq_len;
  assign m_score    = dsel ? bus_b.score    : bus_a.score;

  typedef struct {int digit; int len; int score;} show_t;
  typedef struct {int win; int lose; int score; int len;} res_t;
  show_t show_q[$];
  res_t  res_q[$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: a tick seen while the DUT shows a digit, or entry into WIN/LOSE,
  // is a DUT response and is matched against the head of the relevant queue.
  bit    done_prev = 1'b0;
  show_t s_exp;
  res_t  r_exp;
  always @(negedge Clk) begin
    if (!Rst) begin
      done_prev = 1'b0;
    end else begin
      if (m_timer_en && tick) begin
        if (show_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL show_unexpected: got digit %0d expected none", m_disp);
        end else begin
          s_exp = show_q.pop_front();
          chk("disp_num", int'(m_disp), s_exp.digit);
          chk("show_seq_len", int'(m_len), s_exp.len);
          chk("show_score", int'(m_score), s_exp.score);
          chk("show_busy", int'(m_busy), 1);
        end
      end
      if ((m_win || m_lose) && !done_prev) begin
        if (res_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL result_unexpected: got win=%0d lose=%0d expected none", m_win, m_lose);
        end else begin
          r_exp = res_q.pop_front();
          chk("res_win", int'(m_win), r_exp.win);
          chk("res_lose", int'(m_lose), r_exp.lose);
          chk("res_score", int'(m_score), r_exp.score);
          chk("res_seq_len", int'(m_len), r_exp.len);
          chk("res_disp_blank", int'(m_disp), 31);
          chk("res_busy", int'(m_busy), 0);
          chk("res_timer_en", int'(m_timer_en), 0);
        end
      end
      done_prev = m_win || m_lose;
    end
  end

  task automatic cycle();
    @(posedge Clk);
    #1;
    start   = 1'b0;
    tick    = 1'b0;
    p_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_timer_en"}, int'(m_timer_en), 0);
    chk({tag, "_disp_num"}, int'(m_disp), 31);
    chk({tag, "_seq_len"}, int'(m_len), 0);
    chk({tag, "_score"}, int'(m_score), 0);
    chk({tag, "_win"}, int'(m_win), 0);
    chk({tag, "_lose"}, int'(m_lose), 0);
    chk({tag, "_busy"}, int'(m_busy), 0);
  endtask

  task automatic idle_strays(input string tag);
    repeat (3) begin
      tick = 1'b1; p_valid = 1'b1; p_num = 4'($urandom);
      cycle();
    end
    chk({tag, "_busy"}, int'(m_busy), 0);
    chk({tag, "_seq_len"}, int'(m_len), 0);
  endtask

  task automatic do_reset();
    #3;
    Rst = 1'b0;
    #1;
    check_reset_outputs("midgame_rst");
    chk("midgame_rst_show_q", show_q.size(), 0);
    cycle();
    cycle();
    Rst = 1'b1;
    idle_strays("post_rst_idle");
  endtask

  // Plays one game on the selected DUT. err_round: round whose entry contains
  // one wrong digit (0 = none); reset_round: round in which reset hits mid-entry.
  task automatic play_game(input bit sel, input int maxlen, input int err_round,
                           input int reset_round);
    int seq[$];
    int sc;
    int r;
    int n;
    int err_idx;
    int ew, el;
    bit done;
    sc   = 0;
    done = 1'b0;
    ew   = 0;
    el   = 0;
    dsel = sel;
    r = $urandom_range(0, 15);
    randNum = 4'(r);
    start = 1'b1;
    cycle();
    seq.push_back(r);
    for (int round = 1; !done; round++) begin
      cycle();
      randNum = 4'($urandom);
      n = seq.size();
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) begin
          p_valid = 1'($urandom); p_num = 4'($urandom); start = 1'($urandom);
          cycle();
        end
        show_q.push_back('{seq[i], n, sc});
        tick = 1'b1; p_valid = 1'($urandom); p_num = 4'($urandom); start = 1'($urandom);
        cycle();
      end
      err_idx = (round == err_round) ? int'($urandom_range(0, n - 1)) : -1;
      for (int i = 0; i < n && !done; i++) begin
        if (round == reset_round && i == n / 2) begin
          do_reset();
          return;
        end
        repeat ($urandom_range(0, 2)) begin
          tick = 1'($urandom); start = 1'($urandom); p_num = 4'($urandom);
          cycle();
        end
        tick = 1'($urandom);
        p_valid = 1'b1;
        if (i == err_idx) begin
          p_num = 4'(seq[i] ^ int'($urandom_range(1, 15)));
          res_q.push_back('{0, 1, sc, n});
          el = 1; done = 1'b1;
        end else begin
          p_num = 4'(seq[i]);
          if (i == n - 1) begin
            sc++;
            if (n == maxlen) begin
              res_q.push_back('{1, 0, sc, n});
              ew = 1; done = 1'b1;
            end else begin
              r = $urandom_range(0, 15);
              randNum = 4'(r);
              seq.push_back(r);
            end
          end
        end
        cycle();
      end
    end
    repeat (3) begin
      tick = 1'b1; p_valid = 1'b1; p_num = 4'($urandom);
      cycle();
    end
    chk("hold_win", int'(m_win), ew);
    chk("hold_lose", int'(m_lose), el);
    chk("hold_score", int'(m_score), sc);
    chk("hold_seq_len", int'(m_len), seq.size());
    chk("hold_disp_blank", int'(m_disp), 31);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    #3;
    check_reset_outputs("por_a");
    dsel = 1'b1;
    #1;
    check_reset_outputs("por_b");
    dsel = 1'b0;
    cycle();
    cycle();
    Rst = 1'b1;
    idle_strays("idle_a");

    play_game(1'b0, 16, 2, 0);
    play_game(1'b0, 16, 4, 0);
    play_game(1'b1, 2, 0, 0);
    play_game(1'b1, 2, 0, 0);
    play_game(1'b1, 2, 2, 0);
    play_game(1'b0, 16, 0, 3);
    play_game(1'b0, 16, 0, 0);
    play_game(1'b0, 16, 1, 0);

    repeat (2) cycle();
    chk("show_q_drained", show_q.size(), 0);
    chk("res_q_drained", res_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_round_ctrl.md
SEQ_ROUND_CTRL -- requirements
Module: seq_round_ctrl

Interface
REQ-001 Parameter MAX_LEN, default 16, sets maximum sequence length (legal range 2..16).
REQ-002 Clk  input  1  system clock; all state updates on rising edge.
REQ-003 Rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse (from shaped game button) that begins a new game.
REQ-005 randNum  input  4  random digit source, sampled only in APPEND.
REQ-006 tick  input  1  one-cycle pulse from the 1 s timer.
REQ-007 p_valid  input  1  one-cycle pulse (from shaped player button) that enters p_num.
REQ-008 p_num  input  4  player digit from switches.
REQ-009 timer_en  output  1  timer enable, high only in SHOW.
REQ-010 disp_num  output  5  digit for sequence display; 5'h1F means blank.
REQ-011 seq_len  output  5  current number of stored digits.
REQ-012 score  output  5  completed rounds.
REQ-013 win  output  1  high while in WIN.
REQ-014 lose  output  1  high while in LOSE.
REQ-015 busy  output  1  high in APPEND, SHOW and INPUT.

Function
REQ-016 The block SHALL hold a MAX_LEN x 4-bit sequence buffer, a 5-bit length counter (len) and a 5-bit index (idx).
REQ-017 The FSM SHALL have states IDLE, APPEND, SHOW, INPUT, WIN and LOSE.
REQ-018 IDLE/WIN/LOSE: start SHALL clear len, idx and score and go to APPEND next cycle; all other inputs are ignored.
REQ-019 APPEND: the block SHALL write randNum to buf[len], increment len, clear idx and go to SHOW, taking exactly one cycle.
REQ-020 SHOW: timer_en=1 and disp_num={1'b0,buf[idx]}.
REQ-020a SHOW, on tick: if idx==len-1, clear idx and go to INPUT; otherwise increment idx.
REQ-021 INPUT: timer_en=0 and disp_num=5'h1F.
REQ-021a INPUT, on p_valid with p_num==buf[idx]: if idx==len-1, increment score and go to WIN when len==MAX_LEN, else to APPEND; otherwise increment idx.
REQ-022 INPUT, on p_valid with p_num!=buf[idx]: go to LOSE; score is held.
REQ-023 tick outside SHOW and p_valid outside INPUT SHALL be ignored with no state change.
REQ-024 start SHALL be ignored in APPEND, SHOW and INPUT.
REQ-025 Simultaneous tick and p_valid: only the input relevant to the current state acts.
REQ-026 Buffer contents SHALL persist across rounds: each round replays all earlier digits plus one new digit.
REQ-027 len SHALL never exceed MAX_LEN and score SHALL never exceed MAX_LEN; no wrap-around is permitted.
REQ-028 Outputs are registered or decoded from state only, with no combinational path from inputs to outputs.
REQ-029 In WIN and LOSE, disp_num SHALL be 5'h1F and timer_en SHALL be 0.

Reset
REQ-030 Rst low SHALL immediately force IDLE, len=0, idx=0, score=0, timer_en=0, disp_num=5'h1F, win=0, lose=0 and busy=0, including mid-SHOW or mid-INPUT.
REQ-031 Buffer contents need not be cleared by reset; they are never read before being written.
REQ-032 After Rst is released, the block SHALL stay in IDLE until start.

Verification
REQ-033 Reset, then start with randNum=7 -> APPEND 1 cycle, then SHOW with disp_num=7, timer_en=1, seq_len=1.
REQ-034 Round 1 digit 7, tick, then p_valid with p_num=7 -> score=1, APPEND, seq_len=2, replay shows 7 then the new digit on successive ticks.
REQ-035 Second-round sequence 7,3 with player input 7 then 5 -> lose=1, score=1, disp_num=5'h1F, busy=0; a following start -> score=0, seq_len=1.
REQ-036 MAX_LEN=2, two rounds entered correctly -> win=1, score=2, seq_len=2; further tick and p_valid produce no change.
REQ-037 Stray inputs: p_valid during SHOW, tick during INPUT and start during SHOW -> idx, state and score unchanged.
REQ-038 Rst asserted mid-INPUT of round 3 -> all outputs reach reset values before the next Clk edge; a fresh game then starts cleanly.
